// File: rtl/multi_mod_ctr_pkg.sv
// rtl/multi_mod_ctr_pkg.sv - shared types and helpers for the multi-channel modulus counter bank
package multi_mod_ctr_pkg;

  // Widest counter/limit supported; helpers operate at this width and callers truncate.
  localparam int MAX_W = 16;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } ctr_op_e;

  // Width of the channel-select field; a single-channel bank still gets one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Unsigned min(val, lim).
  function automatic logic [MAX_W-1:0] clamp(input logic [MAX_W-1:0] val,
                                             input logic [MAX_W-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/mod_ctr_chan.sv
// rtl/mod_ctr_chan.sv - one counter channel: limit register, priority decode, bound compare, event register
module mod_ctr_chan
  import multi_mod_ctr_pkg::*;
#(
  parameter int W   = 3,
  parameter int L   = 2**W - 1,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         casc_inc,
  input  logic         casc_dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         lim_we,
  input  logic [W-1:0] lim_val,
  output logic [W-1:0] cnt,
  output logic         evt,
  output logic         at_max,
  output logic         at_zero,
  output logic         carry,
  output logic         borrow
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] lim_q, lim_d;
  logic         evt_q, evt_d;
  logic [W-1:0] eff_lim;
  logic         inc_eff, dec_eff;
  ctr_op_e      op;

  // A cascaded carry/borrow merges with the external request so both together count once.
  assign inc_eff = inc | casc_inc;
  assign dec_eff = dec | casc_dec;

  // Priority decode, bound checks against the old limit, then clamp to a newly written limit.
  always_comb begin
    op      = OP_HOLD;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    carry   = 1'b0;
    borrow  = 1'b0;
    eff_lim = lim_we ? lim_val : lim_q;
    lim_d   = lim_we ? lim_val : lim_q;

    if (load)                   op = OP_LOAD;
    else if (inc_eff && dec_eff) op = OP_HOLD;
    else if (inc_eff)           op = OP_INC;
    else if (dec_eff)           op = OP_DEC;

    case (op)
      OP_LOAD: cnt_d = W'(clamp(MAX_W'(load_val), MAX_W'(eff_lim)));
      OP_INC: begin
        if (cnt_q == lim_q) begin
          evt_d = 1'b1;
          if (SAT == 0) begin
            cnt_d = '0;
            carry = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      OP_DEC: begin
        if (cnt_q == '0) begin
          evt_d = 1'b1;
          if (SAT == 0) begin
            cnt_d  = lim_q;
            borrow = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase

    // Shrinking the limit below the freshly computed count pulls the count down, silently.
    if (lim_we && (cnt_d > lim_val)) cnt_d = lim_val;
  end

  // Count, limit and event registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lim_q <= W'(L);
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      evt_q <= evt_d;
    end
  end

  assign cnt     = cnt_q;
  assign evt     = evt_q;
  assign at_max  = (cnt_q == lim_q);
  assign at_zero = (cnt_q == '0);

endmodule

// File: rtl/multi_mod_ctr.sv
// rtl/multi_mod_ctr.sv - N-channel up/down modulus counter bank; MULTI_MOD_CTR_CASCADE_EN chains carry/borrow between channels
module multi_mod_ctr
  import multi_mod_ctr_pkg::*;
#(
  parameter int W   = 3,
  parameter int N   = 4,
  parameter int L   = 2**W - 1,
  parameter int SAT = 0,
  localparam int SW = sel_w(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   inc,
  input  logic [N-1:0]   dec,
  input  logic [N-1:0]   load,
  input  logic [N*W-1:0] load_val,
  input  logic           lim_we,
  input  logic [SW-1:0]  lim_sel,
  input  logic [W-1:0]   lim_val,
  output logic [N*W-1:0] cnt,
  output logic [N-1:0]   evt,
  output logic [N-1:0]   at_max,
  output logic [N-1:0]   at_zero
);

  logic [N-1:0] carry;
  logic [N-1:0] borrow;
  logic [N-1:0] casc_inc;
  logic [N-1:0] casc_dec;
  logic [N-1:0] lim_we_ch;

  for (genvar i = 0; i < N; i++) begin : g_ch
    // A select value at or beyond N matches no channel, so the write is dropped.
    assign lim_we_ch[i] = lim_we && (lim_sel == SW'(i));

`ifdef MULTI_MOD_CTR_CASCADE_EN
    if (i == 0) begin : g_head
      assign casc_inc[i] = 1'b0;
      assign casc_dec[i] = 1'b0;
    end else begin : g_link
      assign casc_inc[i] = carry[i-1];
      assign casc_dec[i] = borrow[i-1];
    end
`else
    assign casc_inc[i] = 1'b0;
    assign casc_dec[i] = 1'b0;
`endif

    mod_ctr_chan #(
      .W  (W),
      .L  (L),
      .SAT(SAT)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .casc_inc(casc_inc[i]),
      .casc_dec(casc_dec[i]),
      .load    (load[i]),
      .load_val(load_val[i*W +: W]),
      .lim_we  (lim_we_ch[i]),
      .lim_val (lim_val),
      .cnt     (cnt[i*W +: W]),
      .evt     (evt[i]),
      .at_max  (at_max[i]),
      .at_zero (at_zero[i]),
      .carry   (carry[i]),
      .borrow  (borrow[i])
    );
  end

  // The last channel's carry/borrow (and all of them without cascading) go nowhere.
  logic unused_casc;
  assign unused_casc = ^{carry, borrow};

endmodule

// File: tb/tb_multi_mod_ctr.sv
// tb/tb_multi_mod_ctr.sv - directed self-checking bench for multi_mod_ctr (wrap and saturate instances)
module tb_multi_mod_ctr;

  localparam int W  = 3;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   inc, dec, load;
  logic [N*W-1:0] load_val;
  logic           lim_we;
  logic [SW-1:0]  lim_sel;
  logic [W-1:0]   lim_val;

  logic [N*W-1:0] cnt, cnt_s;
  logic [N-1:0]   evt, at_max, at_zero;
  logic [N-1:0]   evt_s, at_max_s, at_zero_s;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  multi_mod_ctr #(.W(W), .N(N), .SAT(0)) dut (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .lim_we(lim_we), .lim_sel(lim_sel), .lim_val(lim_val),
    .cnt(cnt), .evt(evt), .at_max(at_max), .at_zero(at_zero)
  );

  multi_mod_ctr #(.W(W), .N(N), .SAT(1)) dut_s (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
    .lim_we(lim_we), .lim_sel(lim_sel), .lim_val(lim_val),
    .cnt(cnt_s), .evt(evt_s), .at_max(at_max_s), .at_zero(at_zero_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ch(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic idle();
    inc = '0; dec = '0; load = '0; load_val = '0;
    lim_we = 1'b0; lim_sel = '0; lim_val = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    chk("rst_cnt", cnt, 0);
    chk("rst_evt", evt, 0);
    chk("rst_at_zero", at_zero, 4'hF);
    chk("rst_at_max", at_max, 4'h0);
    reset = 1'b0;

    // 1: free-running inc on channel 0 wraps 7 -> 0 with a single evt.
    inc = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("t1_cnt0_k%0d", k), ch(cnt, 0), k % 8);
      chk($sformatf("t1_evt0_k%0d", k), evt[0], (k == 8));
    end
    idle();

    // 2: dec at 0 wraps to the limit; inc&dec together holds.
    dec = 4'b0010;
    step();
    chk("t2_cnt1_wrap", ch(cnt, 1), 7);
    chk("t2_evt1_wrap", evt[1], 1);
    chk("t2_atmax1", at_max[1], 1);
    inc = 4'b0010;
    step();
    chk("t2_cnt1_both", ch(cnt, 1), 7);
    chk("t2_evt1_both", evt[1], 0);
    idle();

    // 3: shrinking limit clamps count; load clamps to limit; limit 0 pins the channel.
    load = 4'b0100; load_val[2*W +: W] = 3'd6;
    step();
    chk("t3_cnt2_load6", ch(cnt, 2), 6);
    idle();
    lim_we = 1'b1; lim_sel = 2'd2; lim_val = 3'd4;
    step();
    chk("t3_cnt2_clamp", ch(cnt, 2), 4);
    chk("t3_atmax2", at_max[2], 1);
    chk("t3_evt2", evt[2], 0);
    idle();
    load = 4'b0100; load_val[2*W +: W] = 3'd7;
    step();
    chk("t3_cnt2_load7", ch(cnt, 2), 4);
    idle();
    lim_we = 1'b1; lim_sel = 2'd3; lim_val = 3'd0;
    step();
    idle();
    inc = 4'b1000;
    step();
    chk("t3_cnt3_lim0", ch(cnt, 3), 0);
    chk("t3_evt3_lim0", evt[3], 1);
    chk("t3_atmax3_lim0", at_max[3], 1);
    idle();

    // 4: saturating instance holds at both bounds and pulses evt every cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    load = 4'b1000; load_val[3*W +: W] = 3'd7;
    step();
    idle();
    inc = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t4_sat_cnt3_k%0d", k), ch(cnt_s, 3), 7);
      chk($sformatf("t4_sat_evt3_k%0d", k), evt_s[3], 1);
    end
    idle();
    load = 4'b1000; load_val[3*W +: W] = 3'd0;
    step();
    idle();
    dec = 4'b1000;
    step();
    chk("t4_sat_cnt3_dec0", ch(cnt_s, 3), 0);
    chk("t4_sat_evt3_dec0", evt_s[3], 1);
    idle();

    // 5: carry out of channel 0 ripples (cascade build) or stays local (default build).
    reset = 1'b1;
    step();
    reset = 1'b0;
    lim_we = 1'b1; lim_sel = 2'd0; lim_val = 3'd3;
    step();
    lim_sel = 2'd1;
    step();
    idle();
    load = 4'b0011; load_val[0 +: W] = 3'd3; load_val[W +: W] = 3'd3;
    step();
    idle();
    inc = 4'b0001;
    step();
    chk("t5_cnt0", ch(cnt, 0), 0);
    chk("t5_evt0", evt[0], 1);
`ifdef MULTI_MOD_CTR_CASCADE_EN
    chk("t5_cnt1", ch(cnt, 1), 0);
    chk("t5_cnt2", ch(cnt, 2), 1);
    chk("t5_evt1", evt[1], 1);
`else
    chk("t5_cnt1", ch(cnt, 1), 3);
    chk("t5_cnt2", ch(cnt, 2), 0);
    chk("t5_evt1", evt[1], 0);
`endif
    idle();

    // 6: reset mid-activity restores counts and limits.
    inc = 4'b1111; load = 4'b0110; load_val = 12'hFFF;
    reset = 1'b1;
    step();
    chk("t6_cnt", cnt, 0);
    chk("t6_evt", evt, 0);
    chk("t6_at_zero", at_zero, 4'hF);
    chk("t6_at_max", at_max, 4'h0);
    reset = 1'b0;
    idle();
    inc = 4'b0001;
    for (int k = 0; k < 4; k++) step();
    chk("t6_lim0_restored", ch(cnt, 0), 4);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/multi_mod_ctr.md
Name: multi_mod_ctr

Overview:
N-channel up/down counter bank for game timing: score, lives, sprite frame and animation indices.
- Each channel has a runtime-programmable modulus (limit).
- Per channel: increment, decrement, parallel load, wrap or saturate mode, and a registered terminal-event pulse.
- Sits between the frame-tick/event logic and the display/scoring datapath, replacing ad-hoc single counters.

Parameters:
W, 3, counter and limit width in bits (1..16)
N, 4, number of independent channels (1..16)
L, 2**W-1, reset value of every channel's limit register
SAT, 0, per-bank mode: 0 = wrap at bounds, 1 = saturate at bounds

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
inc  in  N  per-channel increment request
dec  in  N  per-channel decrement request
load  in  N  per-channel parallel load strobe
load_val  in  N*W  load values, channel i at [i*W +: W]
lim_we  in  1  limit register write strobe
lim_sel  in  $clog2(N) (min 1)  channel selected for limit write
lim_val  in  W  new limit value
cnt  out  N*W  current counts, channel i at [i*W +: W]
evt  out  N  one-cycle pulse: channel wrapped (SAT=0) or hit a bound (SAT=1) on the last update
at_max  out  N  combinational: cnt[i] == lim[i]
at_zero  out  N  combinational: cnt[i] == 0

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- On reset, all of the following take effect at the next clk edge:
  - cnt = 0 and evt = 0 for all channels.
  - lim = W'(L) for all channels.
  - at_zero = all ones; at_max = (L == 0 ? all ones : 0).
- Reset overrides every other input.
- Per channel i, the update priority on each clk edge is:
  1. load[i]: cnt <= min(load_val[i], effective_lim). evt = 0.
  2. inc[i] & dec[i]: no change. evt = 0.
  3. inc[i] only:
     - If cnt == lim: SAT=0 gives cnt <= 0, evt = 1; SAT=1 holds, evt = 1.
     - Else cnt <= cnt + 1, evt = 0.
  4. dec[i] only:
     - If cnt == 0: SAT=0 gives cnt <= lim, evt = 1; SAT=1 holds, evt = 1.
     - Else cnt <= cnt - 1, evt = 0.
  5. Otherwise: hold, evt = 0.
- Latency and timing:
  - One cycle from request to new cnt.
  - evt is registered and asserted in the same cycle the updated cnt is visible.
  - evt lasts exactly one cycle per triggering event.
  - A sustained inc at the limit with SAT=1 produces evt on every cycle.
- Limit write (lim_we, channel lim_sel):
  - lim[sel] <= lim_val at the next edge.
  - effective_lim is lim_val for the written channel in that cycle, and the current lim otherwise.
  - If the written channel has cnt > lim_val after the normal update is computed, cnt is clamped to lim_val. evt = 0 for that clamp.
  - Inc/dec bound checks in the write cycle use the OLD limit. The clamp then applies to the result.
  - If lim_sel >= N, the write is ignored.
- Limit 0: the channel stays at 0. With SAT=0, every inc or dec produces evt; with SAT=1, every request produces evt.
- Arithmetic is modulo 2^W internally. Compares are unsigned, full width. No overflow is possible beyond lim <= 2^W-1.
- Channels are fully independent, except as stated under Optional Feature.

Optional Feature:
- Macro: MULTI_MOD_CTR_CASCADE_EN.
- When defined, the bank operates as a cascaded counter chain:
  - Channel i+1 (i < N-1) sees an internal increment whenever channel i produces a wrap on an inc in the same cycle. The internal increment is combinational, no extra latency, so a multi-digit BCD/score chain ripples within one clock.
  - The internal increment ORs with the external inc[i+1]; both together count once.
  - Same-cycle dec or load on channel i+1 keeps the normal priority (load wins; inc & dec gives no change).
  - Borrow on dec at 0 likewise cascades as a decrement to channel i+1.
  - With SAT=1, no carry or borrow is generated.
- When undefined: no inter-channel logic; all channels are independent.

Decomposition:
- Package multi_mod_ctr_pkg holds:
  - typedef ctr_op_e {OP_HOLD, OP_LOAD, OP_INC, OP_DEC}.
  - Function clamp(val, lim).
  - Localparam helpers for the lim_sel width.
- Sub-module mod_ctr_chan (one channel) holds:
  - cnt and lim registers, priority decode, bound compare, evt register.
  - Exports carry and borrow for the cascade.
- Top level: generate loop over N, cascade wiring under the macro, and limit-write demux.

Test Plan:
1. Reset, then inc[0] held 9 cycles (W=3, L=7) -> cnt0 steps 0..7, then 0, then 1; evt[0] high only in the cycle cnt0 reads 0.
2. dec[1] from 0 -> cnt1 = 7, evt[1] = 1. Then inc[1] & dec[1] together -> cnt1 stays 7, evt = 0.
3. Write lim ch2 = 4 while cnt2 = 6 -> next cycle cnt2 = 4, lim2 = 4, at_max[2] = 1, evt[2] = 0. Then load 7 -> cnt2 = 4 (clamped).
4. SAT=1 build, inc ch3 held at 7 for 3 cycles -> cnt3 stays 7, evt[3] high all 3 cycles. dec at 0 -> holds 0, evt = 1.
5. CASCADE_EN, lim0 = lim1 = 3, cnt0 = 3, cnt1 = 3, inc[0] -> next cycle cnt0 = 0, cnt1 = 0, cnt2 = 1, evt[0] = evt[1] = 1.
6. reset asserted mid-count with inc and load active -> next cycle all cnt = 0, all lim = 7, evt = 0; prior limit writes are discarded.
